// File: rtl/ibex_itcm_pkg.sv
// Shared types and helpers for the ITCM instruction-fetch path.
package ibex_itcm_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } itcm_resp_t;

    localparam logic [31:0] ITCM_BASE_DEFAULT  = 32'h0000_0000;
    localparam int unsigned ITCM_WORDS_DEFAULT = 4096;

    // Unsigned wrap-around subtraction also rejects addresses below the base.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned words);
        logic [31:0] offset;
        logic [33:0] span;
        offset = addr - base;
        span   = 34'(words) * 34'd4;
        return {2'b00, offset} < span;
    endfunction

endpackage

// File: rtl/ibex_instr_resp_pipe.sv
// In-order response delay line; WAIT_STATES deep, pure wire when WAIT_STATES is 0.
module ibex_instr_resp_pipe
    import ibex_itcm_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  itcm_resp_t resp_i,
    output itcm_resp_t resp_o
);

    if (WAIT_STATES == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign resp_o         = resp_i;
    end else begin : g_pipe
        logic [WAIT_STATES-1:0] valid_d, valid_q;
        logic [WAIT_STATES-1:0] err_d, err_q;
        logic [31:0]            rdata_d [WAIT_STATES];
        logic [31:0]            rdata_q [WAIT_STATES];

        always_comb begin
            valid_d[0] = resp_i.valid;
            err_d[0]   = resp_i.err;
            rdata_d[0] = resp_i.rdata;
            for (int i = 1; i < WAIT_STATES; i++) begin
                valid_d[i] = valid_q[i-1];
                err_d[i]   = err_q[i-1];
                rdata_d[i] = rdata_q[i-1];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= '0;
                err_q   <= '0;
            end else begin
                valid_q <= valid_d;
                err_q   <= err_d;
            end
        end

        // Data flops carry no reset; they only load alongside a valid entry.
        always_ff @(posedge clk_i) begin
            for (int i = 0; i < WAIT_STATES; i++) begin
                if (valid_d[i]) begin
                    rdata_q[i] <= rdata_d[i];
                end
            end
        end

        assign resp_o.valid = valid_q[WAIT_STATES-1];
        assign resp_o.err   = err_q[WAIT_STATES-1];
        assign resp_o.rdata = rdata_q[WAIT_STATES-1];
    end

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// Ibex instruction-fetch bus responder: grants word fetches, reads the ITCM through the
// arbiter and answers in order with a fixed latency, flagging range and SRAM errors.
module ibex_instr_bus_responder
    import ibex_itcm_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE       = ITCM_BASE_DEFAULT,
    parameter int unsigned MEM_WORDS       = ITCM_WORDS_DEFAULT,
    parameter int unsigned MEM_AW          = $clog2(MEM_WORDS),
    parameter int unsigned WAIT_STATES     = 0,
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_rerr_i,
    output logic [CNT_W-1:0]  outstanding_o
);

    logic [31:0]      offset;
    logic             in_range;
    logic             slot_free;
    logic             resp_fire;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             s0_valid_d, s0_valid_q;
    logic             s0_oor_d, s0_oor_q;
    itcm_resp_t       pipe_in, pipe_out;
    logic             unused_offset;

    assign offset        = instr_addr_i - ADDR_BASE;
    assign in_range      = addr_in_range(instr_addr_i, ADDR_BASE, MEM_WORDS);
    assign mem_addr_o    = offset[MEM_AW+1:2];
    assign unused_offset = ^{offset[31:2] >> MEM_AW, offset[1:0]};

    assign resp_fire   = pipe_out.valid;
    assign slot_free   = (cnt_q < CNT_W'(MAX_OUTSTANDING)) | resp_fire;
    assign mem_req_o   = instr_req_i & in_range & slot_free;
    // Out-of-range fetches skip the SRAM and are granted without the arbiter.
    assign instr_gnt_o = instr_req_i & slot_free & (in_range ? mem_gnt_i : 1'b1);

    always_comb begin
        cnt_d      = cnt_q;
        s0_valid_d = instr_gnt_o;
        s0_oor_d   = instr_gnt_o & ~in_range;
        case ({instr_gnt_o, resp_fire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            s0_valid_q <= 1'b0;
            s0_oor_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            s0_valid_q <= s0_valid_d;
            s0_oor_q   <= s0_oor_d;
        end
    end

    // SRAM data lands one cycle after the grant; merge it with the range flag here.
    always_comb begin
        pipe_in.valid = s0_valid_q;
        pipe_in.err   = s0_oor_q | mem_rerr_i;
        pipe_in.rdata = pipe_in.err ? 32'h0 : mem_rdata_i;
    end

    ibex_instr_resp_pipe #(
        .WAIT_STATES(WAIT_STATES)
    ) u_resp_pipe (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .resp_i(pipe_in),
        .resp_o(pipe_out)
    );

    assign instr_rvalid_o = pipe_out.valid;
    assign instr_err_o    = pipe_out.valid & pipe_out.err;
    assign instr_rdata_o  = (pipe_out.valid & ~pipe_out.err) ? pipe_out.rdata : 32'h0;
    assign outstanding_o  = cnt_q;

    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (instr_req_i && !instr_gnt_o) |=> (instr_req_i && $stable(instr_addr_i)));
    a_mem_gnt_with_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_gnt_i |-> mem_req_o);
    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CNT_W'(MAX_OUTSTANDING));
    a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        resp_fire |-> (cnt_q != '0));

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Directed table-driven bench: three responder instances with different latency settings.
module tb_ibex_instr_bus_responder;

    typedef struct {
        bit          rst;
        bit          req;
        logic [31:0] addr;
        bit          arb;
        bit          inj;
        bit          gnt;
        bit          mreq;
        logic [11:0] maddr;
        bit          rv;
        bit          err;
        logic [31:0] rdata;
        int          cnt;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        arb   [3];
    logic        inj   [3];

    logic        gnt_a, rv_a, err_a, mreq_a, mgnt_a, mre_a;
    logic        gnt_b, rv_b, err_b, mreq_b, mgnt_b, mre_b;
    logic        gnt_c, rv_c, err_c, mreq_c, mgnt_c, mre_c;
    logic [31:0] rd_a, rd_b, rd_c, mrd_a, mrd_b, mrd_c;
    logic [11:0] maddr_a, maddr_b, maddr_c;
    logic [0:0]  cnt_a;
    logic [1:0]  cnt_b, cnt_c;

    assign mgnt_a = mreq_a & arb[0];
    assign mgnt_b = mreq_b & arb[1];
    assign mgnt_c = mreq_c & arb[2];

    function automatic logic [31:0] memword(input logic [11:0] w);
        return (w == 12'd4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(w));
    endfunction

    // SRAM models: one-cycle read latency, error flag injected per access.
    always_ff @(posedge clk) begin
        if (mreq_a && mgnt_a) begin mrd_a <= memword(maddr_a); mre_a <= inj[0]; end
        if (mreq_b && mgnt_b) begin mrd_b <= memword(maddr_b); mre_b <= inj[1]; end
        if (mreq_c && mgnt_c) begin mrd_c <= memword(maddr_c); mre_c <= inj[2]; end
    end

    ibex_instr_bus_responder #(.WAIT_STATES(0), .MAX_OUTSTANDING(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n[0]), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
        .instr_gnt_o(gnt_a), .instr_rvalid_o(rv_a), .instr_rdata_o(rd_a),
        .instr_err_o(err_a), .mem_req_o(mreq_a), .mem_gnt_i(mgnt_a), .mem_addr_o(maddr_a),
        .mem_rdata_i(mrd_a), .mem_rerr_i(mre_a), .outstanding_o(cnt_a)
    );

    ibex_instr_bus_responder #(.WAIT_STATES(2), .MAX_OUTSTANDING(3)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n[1]), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
        .instr_gnt_o(gnt_b), .instr_rvalid_o(rv_b), .instr_rdata_o(rd_b),
        .instr_err_o(err_b), .mem_req_o(mreq_b), .mem_gnt_i(mgnt_b), .mem_addr_o(maddr_b),
        .mem_rdata_i(mrd_b), .mem_rerr_i(mre_b), .outstanding_o(cnt_b)
    );

    ibex_instr_bus_responder #(.WAIT_STATES(3), .MAX_OUTSTANDING(2)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n[2]), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
        .instr_gnt_o(gnt_c), .instr_rvalid_o(rv_c), .instr_rdata_o(rd_c),
        .instr_err_o(err_c), .mem_req_o(mreq_c), .mem_gnt_i(mgnt_c), .mem_addr_o(maddr_c),
        .mem_rdata_i(mrd_c), .mem_rerr_i(mre_c), .outstanding_o(cnt_c)
    );

    function automatic vec_t v(input bit rst, input bit rq, input logic [31:0] a,
                               input bit ar, input bit ij, input bit g, input bit mr,
                               input logic [11:0] ma, input bit rv, input bit er,
                               input logic [31:0] rd, input int cnt);
        vec_t r;
        r.rst = rst; r.req = rq; r.addr = a; r.arb = ar; r.inj = ij; r.gnt = g;
        r.mreq = mr; r.maddr = ma; r.rv = rv; r.err = er; r.rdata = rd; r.cnt = cnt;
        return r;
    endfunction

    // Request row: granted iff g; mem_req expected as mr.
    function automatic vec_t rq(input logic [31:0] a, input bit ar, input bit ij,
                                input bit g, input bit mr, input bit rv, input bit er,
                                input logic [31:0] rd, input int cnt);
        return v(0, 1, a, ar, ij, g, mr, a[13:2], rv, er, rd, cnt);
    endfunction

    function automatic vec_t idle(input bit rv, input bit er, input logic [31:0] rd,
                                  input int cnt);
        return v(0, 0, 32'h0, 0, 0, 0, 0, 12'h0, rv, er, rd, cnt);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input vec_t r);
        rst_n[which] = !r.rst;
        req[which]   = r.req;
        addr[which]  = r.addr;
        arb[which]   = r.arb;
        inj[which]   = r.inj;
    endtask

    task automatic check_row(input int which, input int idx, input vec_t r);
        logic        g, mr, rv, er;
        logic [11:0] ma;
        logic [31:0] rd;
        int          cnt;
        string       tag;
        case (which)
            0:       begin g = gnt_a; mr = mreq_a; ma = maddr_a; rv = rv_a; er = err_a;
                           rd = rd_a; cnt = int'(cnt_a); end
            1:       begin g = gnt_b; mr = mreq_b; ma = maddr_b; rv = rv_b; er = err_b;
                           rd = rd_b; cnt = int'(cnt_b); end
            default: begin g = gnt_c; mr = mreq_c; ma = maddr_c; rv = rv_c; er = err_c;
                           rd = rd_c; cnt = int'(cnt_c); end
        endcase
        tag = $sformatf("dut%0d[%0d]", which, idx);
        cmp({tag, ".gnt"}, 32'(g), 32'(r.gnt));
        cmp({tag, ".mem_req"}, 32'(mr), 32'(r.mreq));
        if (r.mreq) cmp({tag, ".mem_addr"}, 32'(ma), 32'(r.maddr));
        cmp({tag, ".rvalid"}, 32'(rv), 32'(r.rv));
        if (r.rv || r.rst) begin
            cmp({tag, ".err"}, 32'(er), 32'(r.err));
            cmp({tag, ".rdata"}, rd, r.rdata);
        end
        cmp({tag, ".outstanding"}, 32'(cnt), 32'(r.cnt));
    endtask

    task automatic run_table(input int which, input vec_t tab[$]);
        for (int i = 0; i < tab.size(); i++) begin
            @(posedge clk);
            #1;
            drive(which, tab[i]);
            @(negedge clk);
            check_row(which, i, tab[i]);
        end
        @(posedge clk);
        #1;
        drive(which, idle(0, 0, 0, 0));
    endtask

    vec_t ta[$];
    vec_t tb[$];
    vec_t tc[$];
    vec_t rst_row;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; addr[i] = 32'h0; arb[i] = 1'b0; inj[i] = 1'b0;
        end
        rst_row = v(1, 0, 32'h0, 0, 0, 0, 0, 12'h0, 0, 0, 32'h0, 0);

        // WAIT_STATES=0, MAX_OUTSTANDING=1
        ta.push_back(rst_row);
        ta.push_back(idle(0, 0, 0, 0));
        ta.push_back(rq(32'h10, 1, 0, 1, 1, 0, 0, 0, 0));
        ta.push_back(idle(1, 0, 32'hDEAD_BEEF, 1));
        ta.push_back(idle(0, 0, 0, 0));
        ta.push_back(rq(32'h20, 1, 0, 1, 1, 0, 0, 0, 0));
        ta.push_back(rq(32'h24, 1, 0, 1, 1, 1, 0, 32'hC0DE_0008, 1));
        ta.push_back(rq(32'h4000, 0, 0, 1, 0, 1, 0, 32'hC0DE_0009, 1));
        ta.push_back(rq(32'h28, 1, 0, 1, 1, 1, 1, 32'h0, 1));
        ta.push_back(idle(1, 0, 32'hC0DE_000A, 1));
        ta.push_back(idle(0, 0, 0, 0));
        for (int i = 0; i < 5; i++) ta.push_back(rq(32'h30, 0, 0, 0, 1, 0, 0, 0, 0));
        ta.push_back(rq(32'h30, 1, 1, 1, 1, 0, 0, 0, 0));
        ta.push_back(idle(1, 1, 32'h0, 1));
        ta.push_back(rq(32'h3FFC, 1, 0, 1, 1, 0, 0, 0, 0));
        ta.push_back(idle(1, 0, 32'hC0DE_0FFF, 1));
        ta.push_back(idle(0, 0, 0, 0));

        // WAIT_STATES=2, MAX_OUTSTANDING=3: streaming, OOR interleave, reset mid-flight
        tb.push_back(rst_row);
        tb.push_back(idle(0, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            tb.push_back(rq(32'(4 * k), 1, 0, 1, 1, k >= 3,
                            0, (k >= 3) ? memword(12'(k - 3)) : 32'h0, (k < 3) ? k : 3));
        end
        tb.push_back(idle(1, 0, 32'hC0DE_0005, 3));
        tb.push_back(idle(1, 0, 32'hC0DE_0006, 2));
        tb.push_back(idle(1, 0, 32'hC0DE_0007, 1));
        tb.push_back(idle(0, 0, 0, 0));
        tb.push_back(rq(32'h3C, 1, 0, 1, 1, 0, 0, 0, 0));
        tb.push_back(rq(32'h4000, 1, 0, 1, 0, 0, 0, 0, 1));
        tb.push_back(rq(32'h50, 1, 0, 1, 1, 0, 0, 0, 2));
        tb.push_back(idle(1, 0, 32'hC0DE_000F, 3));
        tb.push_back(idle(1, 1, 32'h0, 2));
        tb.push_back(idle(1, 0, 32'hC0DE_0014, 1));
        tb.push_back(idle(0, 0, 0, 0));
        tb.push_back(rq(32'h40, 1, 0, 1, 1, 0, 0, 0, 0));
        tb.push_back(rq(32'h44, 1, 0, 1, 1, 0, 0, 0, 1));
        tb.push_back(idle(0, 0, 0, 2));
        tb.push_back(rst_row);
        tb.push_back(idle(0, 0, 0, 0));
        tb.push_back(idle(0, 0, 0, 0));
        tb.push_back(rq(32'h48, 1, 0, 1, 1, 0, 0, 0, 0));
        tb.push_back(idle(0, 0, 0, 1));
        tb.push_back(idle(0, 0, 0, 1));
        tb.push_back(idle(1, 0, 32'hC0DE_0012, 1));
        tb.push_back(idle(0, 0, 0, 0));

        // WAIT_STATES=3, MAX_OUTSTANDING=2: throttled continuous request
        tc.push_back(rst_row);
        tc.push_back(idle(0, 0, 0, 0));
        tc.push_back(rq(32'h0, 1, 0, 1, 1, 0, 0, 0, 0));
        tc.push_back(rq(32'h4, 1, 0, 1, 1, 0, 0, 0, 1));
        tc.push_back(rq(32'h8, 1, 0, 0, 0, 0, 0, 0, 2));
        tc.push_back(rq(32'h8, 1, 0, 0, 0, 0, 0, 0, 2));
        tc.push_back(rq(32'h8, 1, 0, 1, 1, 1, 0, 32'hC0DE_0000, 2));
        tc.push_back(rq(32'hC, 1, 0, 1, 1, 1, 0, 32'hC0DE_0001, 2));
        tc.push_back(rq(32'h10, 1, 0, 0, 0, 0, 0, 0, 2));
        tc.push_back(rq(32'h10, 1, 0, 0, 0, 0, 0, 0, 2));
        tc.push_back(rq(32'h10, 1, 0, 1, 1, 1, 0, 32'hC0DE_0002, 2));
        tc.push_back(idle(1, 0, 32'hC0DE_0003, 2));
        tc.push_back(idle(0, 0, 0, 1));
        tc.push_back(idle(0, 0, 0, 1));
        tc.push_back(idle(1, 0, 32'hDEAD_BEEF, 1));
        tc.push_back(idle(0, 0, 0, 0));

        run_table(0, ta);
        run_table(1, tb);
        run_table(2, tc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
